// File: rtl/tx_iq_dac_pacer.sv
// Fractional-rate sample pacer between the TX I/Q interface and the DAC bus.
// Pulls one {Q,I} word per accumulator carry, zero-pads on underrun, and tracks burst statistics.
module tx_iq_dac_pacer #(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int ACC_WIDTH     = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*IQ_DATA_WIDTH-1:0] wifi_iq_pack,
    input  logic                       wifi_iq_valid,
    output logic                       wifi_iq_ready,
    input  logic                       enable,
    input  logic [ACC_WIDTH-1:0]       rate_inc,
    input  logic                       iq_swap,
    input  logic [7:0]                 idle_threshold,
    input  logic                       underrun_clr,
    output logic [IQ_DATA_WIDTH-1:0]   dac_i,
    output logic [IQ_DATA_WIDTH-1:0]   dac_q,
    output logic                       dac_valid,
    output logic                       tx_active,
    output logic [CNT_WIDTH-1:0]       underrun_cnt,
    output logic [CNT_WIDTH-1:0]       last_burst_len
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [ACC_WIDTH-1:0]     r_acc;
    logic                     r_strobe;
    logic [ACC_WIDTH:0]       w_sum;
    logic                     w_take;
    logic                     w_empty;

    logic [IQ_DATA_WIDTH-1:0] r_dac_i;
    logic [IQ_DATA_WIDTH-1:0] r_dac_q;
    logic                     r_dac_valid;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_WIDTH-1:0]     r_burst_cnt;
    logic [CNT_WIDTH-1:0]     w_burst_nxt;
    logic [7:0]               r_idle_cnt;
    logic [7:0]               w_idle_nxt;
    logic [7:0]               w_idle_inc;
    logic [7:0]               w_thr;
    logic [CNT_WIDTH-1:0]     r_underrun_cnt;
    logic [CNT_WIDTH-1:0]     w_underrun_nxt;
    logic [CNT_WIDTH-1:0]     r_last_len;
    logic [CNT_WIDTH-1:0]     w_last_nxt;

    assign w_sum   = {1'b0, r_acc} + {1'b0, rate_inc};
    assign w_take  = r_strobe & wifi_iq_valid;
    assign w_empty = r_strobe & ~wifi_iq_valid;

    // The strobe is the registered carry, so ready never depends combinationally on inputs.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_acc    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_acc    <= w_sum[ACC_WIDTH-1:0];
            r_strobe <= w_sum[ACC_WIDTH];
        end
    end

    // A strobe already in flight when enable drops still completes its handshake here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dac_i     <= '0;
            r_dac_q     <= '0;
            r_dac_valid <= 1'b0;
        end else begin
            r_dac_valid <= r_strobe;
            if (r_strobe) begin
                if (wifi_iq_valid) begin
                    r_dac_i <= iq_swap ? wifi_iq_pack[2*IQ_DATA_WIDTH-1:IQ_DATA_WIDTH]
                                       : wifi_iq_pack[IQ_DATA_WIDTH-1:0];
                    r_dac_q <= iq_swap ? wifi_iq_pack[IQ_DATA_WIDTH-1:0]
                                       : wifi_iq_pack[2*IQ_DATA_WIDTH-1:IQ_DATA_WIDTH];
                end else begin
                    r_dac_i <= '0;
                    r_dac_q <= '0;
                end
            end
        end
    end

    assign w_thr      = (idle_threshold == 8'd0) ? 8'd1 : idle_threshold;
    assign w_idle_inc = r_idle_cnt + 8'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_burst_nxt    = r_burst_cnt;
        w_idle_nxt     = r_idle_cnt;
        w_underrun_nxt = r_underrun_cnt;
        w_last_nxt     = r_last_len;
        case (r_state)
            S_IDLE: begin
                if (w_take && enable) begin
                    w_state_nxt = S_ACTIVE;
                    w_burst_nxt = CNT_WIDTH'(1);
                    w_idle_nxt  = 8'd0;
                end
            end
            S_ACTIVE: begin
                if (w_take) begin
                    w_burst_nxt = sat_inc(r_burst_cnt);
                    w_idle_nxt  = 8'd0;
                end else if (w_empty) begin
                    w_underrun_nxt = sat_inc(r_underrun_cnt);
                    w_idle_nxt     = w_idle_inc;
                    if (w_idle_inc >= w_thr) begin
                        w_state_nxt = S_IDLE;
                        w_last_nxt  = r_burst_cnt;
                    end
                end
                // Dropping enable ends the burst, including any sample taken this cycle.
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                    w_last_nxt  = w_burst_nxt;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (underrun_clr) begin
            w_underrun_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_burst_cnt    <= '0;
            r_idle_cnt     <= 8'd0;
            r_underrun_cnt <= '0;
            r_last_len     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_burst_cnt    <= w_burst_nxt;
            r_idle_cnt     <= w_idle_nxt;
            r_underrun_cnt <= w_underrun_nxt;
            r_last_len     <= w_last_nxt;
        end
    end

    assign wifi_iq_ready  = r_strobe;
    assign dac_i          = r_dac_i;
    assign dac_q          = r_dac_q;
    assign dac_valid      = r_dac_valid;
    assign tx_active      = (r_state == S_ACTIVE);
    assign underrun_cnt   = r_underrun_cnt;
    assign last_burst_len = r_last_len;

endmodule

// File: tb/tb_tx_iq_dac_pacer.sv
// Scoreboard bench for tx_iq_dac_pacer: the driver queues expected DAC words at each handshake,
// a monitor pops them on dac_valid; a 4-bit-counter instance covers counter saturation.
module tb_tx_iq_dac_pacer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pack;
    logic        valid;
    logic        enable;
    logic [15:0] rate_inc;
    logic        iq_swap;
    logic [7:0]  idle_threshold;
    logic        underrun_clr;

    logic        ready;
    logic [15:0] dac_i, dac_q;
    logic        dac_valid, tx_active;
    logic [15:0] underrun_cnt, last_burst_len;

    logic        s_ready;
    logic [15:0] s_dac_i, s_dac_q;
    logic        s_dac_valid, s_tx_active;
    logic [3:0]  s_underrun_cnt, s_last_burst_len;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    tx_iq_dac_pacer #(.IQ_DATA_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .wifi_iq_pack(pack), .wifi_iq_valid(valid), .wifi_iq_ready(ready),
        .enable(enable), .rate_inc(rate_inc), .iq_swap(iq_swap), .idle_threshold(idle_threshold),
        .underrun_clr(underrun_clr), .dac_i(dac_i), .dac_q(dac_q), .dac_valid(dac_valid),
        .tx_active(tx_active), .underrun_cnt(underrun_cnt), .last_burst_len(last_burst_len)
    );

    tx_iq_dac_pacer #(.IQ_DATA_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .wifi_iq_pack(pack), .wifi_iq_valid(valid), .wifi_iq_ready(s_ready),
        .enable(enable), .rate_inc(rate_inc), .iq_swap(iq_swap), .idle_threshold(idle_threshold),
        .underrun_clr(underrun_clr), .dac_i(s_dac_i), .dac_q(s_dac_q), .dac_valid(s_dac_valid),
        .tx_active(s_tx_active), .underrun_cnt(s_underrun_cnt), .last_burst_len(s_last_burst_len)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input int k);
        return {16'(k * 3 + 16'h0101), 16'(k) ^ 16'hA5A5};
    endfunction

    // Waits for the next strobe, presents the word for that cycle and queues its expected output.
    task automatic send(input logic [31:0] w, input logic v, input logic sw,
                        input logic [31:0] e, input logic clr);
        int n = 0;
        pack    = w;
        valid   = v;
        iq_swap = sw;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_wait: got no ready within %0d cycles, expected a strobe", n);
        end else begin
            exp_q.push_back(e);
            underrun_clr = clr;
        end
        @(negedge clk);
        underrun_clr = 1'b0;
        valid        = 1'b0;
    endtask

    task automatic gap();
        send(32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, {31'b0, ready}, 32'h0);
        chk({tag, "_dac_i"}, {16'b0, dac_i}, 32'h0);
        chk({tag, "_dac_q"}, {16'b0, dac_q}, 32'h0);
        chk({tag, "_dac_valid"}, {31'b0, dac_valid}, 32'h0);
        chk({tag, "_tx_active"}, {31'b0, tx_active}, 32'h0);
        chk({tag, "_underrun"}, {16'b0, underrun_cnt}, 32'h0);
        chk({tag, "_last_len"}, {16'b0, last_burst_len}, 32'h0);
    endtask

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (dac_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
                chk("dac_qi", {dac_q, dac_i}, e);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] sw_word [4];
        logic        sw_sel  [4];
        logic [31:0] sw_exp  [4];
        int cnt, adj;
        logic prev;

        sw_word = '{32'h1234_ABCD, 32'h1234_ABCD, 32'h00FF_8001, 32'hFFFF_0000};
        sw_sel  = '{1'b0, 1'b1, 1'b1, 1'b0};
        sw_exp  = '{32'h1234_ABCD, 32'hABCD_1234, 32'h8001_00FF, 32'hFFFF_0000};

        rst = 1'b1; enable = 1'b0; valid = 1'b0; pack = '0; iq_swap = 1'b0;
        underrun_clr = 1'b0; rate_inc = 16'd13107; idle_threshold = 8'd8;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        // Swap and packing
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(sw_word[k], 1'b1, sw_sel[k], sw_exp[k], 1'b0);
            if (k == 0) chk("tx_active_rise", {31'b0, tx_active}, 32'h1);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("swap_last_len", {16'b0, last_burst_len}, 32'd4);
        chk("swap_tx_active", {31'b0, tx_active}, 32'h0);

        // Nominal pacing, valid held high, new word every cycle
        cnt = 0; adj = 0; prev = 1'b0;
        enable = 1'b1; valid = 1'b1; iq_swap = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            pack = {16'(i), ~16'(i)};
            if (ready) begin
                exp_q.push_back(pack);
                cnt++;
                if (prev) adj++;
            end
            prev = ready;
        end
        enable = 1'b0; valid = 1'b0;
        chk("nominal_count_ok", {31'b0, (cnt == 199 || cnt == 200)}, 32'h1);
        chk("nominal_adjacent", 32'(adj), 32'h0);
        repeat (2) @(negedge clk);
        chk("nominal_last_len", {16'b0, last_burst_len}, 32'(cnt));

        // Underrun: 50 samples, 3-strobe gap, 20 samples, 8 trailing empties
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        enable = 1'b1; idle_threshold = 8'd8;
        for (int k = 0; k < 50; k++) send(word_of(k), 1'b1, 1'b0, word_of(k), 1'b0);
        for (int k = 0; k < 3; k++) gap();
        chk("gap_tx_active", {31'b0, tx_active}, 32'h1);
        for (int k = 50; k < 70; k++) send(word_of(k), 1'b1, 1'b1, {word_of(k)[15:0], word_of(k)[31:16]}, 1'b0);
        for (int k = 0; k < 7; k++) gap();
        chk("idle7_tx_active", {31'b0, tx_active}, 32'h1);
        gap();
        chk("idle8_tx_active", {31'b0, tx_active}, 32'h0);
        chk("underrun_cnt", {16'b0, underrun_cnt}, 32'd11);
        chk("last_len_70", {16'b0, last_burst_len}, 32'd70);
        chk("small_last_len_sat", {28'b0, s_last_burst_len}, 32'hF);
        chk("small_underrun", {28'b0, s_underrun_cnt}, 32'd11);

        // Counter saturation and clear priority
        idle_threshold = 8'd255;
        send(32'h0BAD_F00D, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0);
        for (int k = 0; k < 20; k++) gap();
        chk("underrun_31", {16'b0, underrun_cnt}, 32'd31);
        chk("small_underrun_sat", {28'b0, s_underrun_cnt}, 32'hF);
        send(32'h1111_2222, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("clr_priority", {16'b0, underrun_cnt}, 32'h0);
        chk("small_clr_priority", {28'b0, s_underrun_cnt}, 32'h0);
        gap();
        chk("underrun_after_clr", {16'b0, underrun_cnt}, 32'd1);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("sat_last_len", {16'b0, last_burst_len}, 32'd1);

        // idle_threshold = 0 behaves as 1
        enable = 1'b1; idle_threshold = 8'd0;
        for (int k = 0; k < 3; k++) send(word_of(k + 100), 1'b1, 1'b0, word_of(k + 100), 1'b0);
        gap();
        chk("thr0_tx_active", {31'b0, tx_active}, 32'h0);
        chk("thr0_last_len", {16'b0, last_burst_len}, 32'd3);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Enable dropped mid-burst
        idle_threshold = 8'd8; enable = 1'b1;
        for (int k = 0; k < 30; k++) send(word_of(k + 200), 1'b1, 1'b0, word_of(k + 200), 1'b0);
        enable = 1'b0;
        @(negedge clk);
        chk("en_ready", {31'b0, ready}, 32'h0);
        chk("en_tx_active", {31'b0, tx_active}, 32'h0);
        chk("en_last_len", {16'b0, last_burst_len}, 32'd30);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        chk("en_ready_stopped", 32'(cnt), 32'h0);

        // Reset mid-burst
        enable = 1'b1;
        for (int k = 0; k < 30; k++) send(word_of(k + 300), 1'b1, 1'b0, word_of(k + 300), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("midrst");
        rst = 1'b0; enable = 1'b0;
        @(negedge clk);

        // Rate extremes
        rate_inc = 16'd0; enable = 1'b1; cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        chk("rate0_strobes", 32'(cnt), 32'h0);
        enable = 1'b0;
        @(negedge clk);
        rate_inc = 16'hFFFF; enable = 1'b1; cnt = 0;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        chk("rate_max_strobes", 32'(cnt), 32'd65535);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
